// File: rtl/m_ext_wb_arbiter.sv
// m_ext_wb_arbiter
// Shares the single register-file write port between the main pipeline
// writeback (always wins) and M-extension results from the M5 stage.
// M results that lose arbitration are held in an in-order circular buffer.
// The buffer drives an issue stall toward decode and reports pending
// destinations for RAW hazard detection.
//
// Ports:
//   clk_i, rsn_i              clock, asynchronous active-low reset
//   core_we_i/waddr_i/wdata_i main pipeline writeback request
//   m_valid_i/we_i/waddr_i/wdata_i  M5 result
//   rf_we_o/waddr_o/wdata_o   register-file write port
//   m_issue_stall_o           decode must not issue a new M-op
//   hz_raddr_a_i/b_i          hazard query addresses (rs1, rs2)
//   hz_pending_a_o/b_o        queried register has a live buffered write
//   overflow_o                sticky: an M result was lost
//
// Handshake: there is no back-pressure on either input. A core write is
// always taken in the cycle it is presented. An M result is taken in its
// cycle by bypass or by push; if it cannot be taken it is dropped and
// overflow_o is raised. m_issue_stall_o is the only flow control, and it
// acts upstream of M1.
module m_ext_wb_arbiter #(
    parameter int WORD_SIZE = 32,
    parameter int REG_SIZE  = 5,
    parameter int DEPTH     = 8
) (
    input  logic                 clk_i,
    input  logic                 rsn_i,
    input  logic                 core_we_i,
    input  logic [REG_SIZE-1:0]  core_waddr_i,
    input  logic [WORD_SIZE-1:0] core_wdata_i,
    input  logic                 m_valid_i,
    input  logic                 m_we_i,
    input  logic [REG_SIZE-1:0]  m_waddr_i,
    input  logic [WORD_SIZE-1:0] m_wdata_i,
    output logic                 rf_we_o,
    output logic [REG_SIZE-1:0]  rf_waddr_o,
    output logic [WORD_SIZE-1:0] rf_wdata_o,
    output logic                 m_issue_stall_o,
    input  logic [REG_SIZE-1:0]  hz_raddr_a_i,
    input  logic [REG_SIZE-1:0]  hz_raddr_b_i,
    output logic                 hz_pending_a_o,
    output logic                 hz_pending_b_o,
    output logic                 overflow_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0]     r_live;
    logic [REG_SIZE-1:0]  r_waddr [DEPTH];
    logic [WORD_SIZE-1:0] r_wdata [DEPTH];
    logic [PW-1:0]        r_head;
    logic [PW-1:0]        r_tail;
    logic [CW-1:0]        r_count;
    logic                 r_overflow;

    logic             w_m_req;
    logic             w_core_kill;
    logic             w_m_killed;
    logic             w_empty;
    logic             w_full;
    logic             w_pop;
    logic             w_bypass;
    logic             w_push_req;
    logic             w_push;
    logic             w_drop;
    logic [DEPTH-1:0] w_occ;
    logic [DEPTH-1:0] w_kill_mask;
    logic [DEPTH-1:0] w_live_next;
    logic             w_pend_a;
    logic             w_pend_b;

    function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign w_m_req     = m_valid_i & m_we_i & (m_waddr_i != '0);
    assign w_core_kill = core_we_i & (core_waddr_i != '0);
    // A same-cycle M result to the same register is older than the core
    // write, so it is simply discarded.
    assign w_m_killed  = w_m_req & w_core_kill & (m_waddr_i == core_waddr_i);
    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == CW'(DEPTH));
    assign w_pop       = ~core_we_i & ~w_empty;
    assign w_bypass    = ~core_we_i & w_empty & w_m_req;
    assign w_push_req  = w_m_req & ~w_bypass & ~w_m_killed;
    // When full, a same-cycle pop frees the slot the push needs.
    assign w_push      = w_push_req & (~w_full | w_pop);
    assign w_drop      = w_push_req & w_full & ~w_pop;

    // Occupancy is derived from the distance of each slot from the head,
    // so stale live bits in free slots never matter.
    always_comb begin
        int off;
        off         = 0;
        w_occ       = '0;
        w_kill_mask = '0;
        w_pend_a    = 1'b0;
        w_pend_b    = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (i >= int'(r_head)) off = i - int'(r_head);
            else                   off = i + DEPTH - int'(r_head);
            w_occ[i]       = (off < int'(r_count));
            w_kill_mask[i] = w_core_kill & (r_waddr[i] == core_waddr_i);
            if (w_occ[i] && r_live[i] && (r_waddr[i] == hz_raddr_a_i)) w_pend_a = 1'b1;
            if (w_occ[i] && r_live[i] && (r_waddr[i] == hz_raddr_b_i)) w_pend_b = 1'b1;
        end
    end

    always_comb begin
        w_live_next = r_live & ~w_kill_mask;
        if (w_pop)  w_live_next[r_head] = 1'b0;
        if (w_push) w_live_next[r_tail] = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            r_live     <= '0;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_live <= w_live_next;
            if (w_pop)  r_head <= f_inc(r_head);
            if (w_push) r_tail <= f_inc(r_tail);
            if (w_push && !w_pop)      r_count <= r_count + CW'(1);
            else if (w_pop && !w_push) r_count <= r_count - CW'(1);
            if (w_drop) r_overflow <= 1'b1;
        end
    end

    // Payload storage needs no reset: it is only read where live/occupied.
    always_ff @(posedge clk_i) begin
        if (rsn_i && w_push) begin
            r_waddr[r_tail] <= m_waddr_i;
            r_wdata[r_tail] <= m_wdata_i;
        end
    end

    always_comb begin
        rf_we_o    = 1'b0;
        rf_waddr_o = '0;
        rf_wdata_o = '0;
        if (rsn_i) begin
            if (core_we_i) begin
                rf_we_o    = 1'b1;
                rf_waddr_o = core_waddr_i;
                rf_wdata_o = core_wdata_i;
            end else if (!w_empty) begin
                // Killed entries still pop, but write nothing.
                rf_we_o    = r_live[r_head];
                rf_waddr_o = r_waddr[r_head];
                rf_wdata_o = r_wdata[r_head];
            end else if (w_m_req) begin
                rf_we_o    = 1'b1;
                rf_waddr_o = m_waddr_i;
                rf_wdata_o = m_wdata_i;
            end
        end
    end

    // Five M-ops may already be in M1..M5 when the stall is seen.
    assign m_issue_stall_o = rsn_i & (int'(r_count) >= DEPTH - 5);
    assign hz_pending_a_o  = rsn_i & (hz_raddr_a_i != '0) & w_pend_a;
    assign hz_pending_b_o  = rsn_i & (hz_raddr_b_i != '0) & w_pend_b;
    assign overflow_o      = r_overflow;

endmodule

// File: tb/tb_m_ext_wb_arbiter.sv
module tb_m_ext_wb_arbiter;
  localparam int W = 32;
  localparam int R = 5;
  localparam int D = 8;

  // clock / reset
  logic clk = 1'b0;
  logic rsn_i = 1'b1;
  always #5 clk = ~clk;

  logic         core_we = 1'b0;
  logic [R-1:0] core_waddr = '0;
  logic [W-1:0] core_wdata = '0;
  logic         m_valid = 1'b0;
  logic         m_we = 1'b0;
  logic [R-1:0] m_waddr = '0;
  logic [W-1:0] m_wdata = '0;
  logic [R-1:0] hz_a = '0;
  logic [R-1:0] hz_b = '0;
  logic         rf_we_o;
  logic [R-1:0] rf_waddr_o;
  logic [W-1:0] rf_wdata_o;
  logic         m_issue_stall_o;
  logic         hz_pending_a_o;
  logic         hz_pending_b_o;
  logic         overflow_o;

  m_ext_wb_arbiter #(.WORD_SIZE(W), .REG_SIZE(R), .DEPTH(D)) dut (
    .clk_i(clk), .rsn_i(rsn_i),
    .core_we_i(core_we), .core_waddr_i(core_waddr), .core_wdata_i(core_wdata),
    .m_valid_i(m_valid), .m_we_i(m_we), .m_waddr_i(m_waddr), .m_wdata_i(m_wdata),
    .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
    .m_issue_stall_o(m_issue_stall_o),
    .hz_raddr_a_i(hz_a), .hz_raddr_b_i(hz_b),
    .hz_pending_a_o(hz_pending_a_o), .hz_pending_b_o(hz_pending_b_o),
    .overflow_o(overflow_o)
  );

  // reference model: in-order list of buffered M results
  typedef struct packed {
    logic         live;
    logic [R-1:0] addr;
    logic [W-1:0] data;
  } ent_t;
  ent_t mq[$];
  logic m_ovf = 1'b0;
  logic [W-1:0] exp_q[$];

  logic         exp_we;
  logic [R-1:0] exp_addr;
  logic [W-1:0] exp_data;
  logic         exp_stall, exp_pa, exp_pb, exp_ovf;

  int errors = 0;
  int checks = 0;

  // driver: apply one cycle of inputs at posedge+1, go to negedge and
  // derive the expected outputs from the model
  task automatic drive(input logic cwe, input logic [R-1:0] ca, input logic [W-1:0] cd,
                       input logic mv, input logic [R-1:0] ma, input logic [W-1:0] md,
                       input logic [R-1:0] ha, input logic [R-1:0] hb);
    logic m_req;
    core_we = cwe; core_waddr = ca; core_wdata = cd;
    m_valid = mv; m_we = mv; m_waddr = ma; m_wdata = md;
    hz_a = ha; hz_b = hb;
    @(negedge clk);
    m_req = mv && (ma != 0);
    exp_we = 1'b0; exp_addr = '0; exp_data = '0;
    if (cwe) begin
      exp_we = 1'b1; exp_addr = ca; exp_data = cd;
    end else if (mq.size() > 0) begin
      exp_we = mq[0].live; exp_addr = mq[0].addr; exp_data = mq[0].data;
    end else if (m_req) begin
      exp_we = 1'b1; exp_addr = ma; exp_data = md;
    end
    exp_stall = (mq.size() >= D - 5);
    exp_pa = 1'b0; exp_pb = 1'b0;
    foreach (mq[k]) begin
      if (mq[k].live && ha != 0 && mq[k].addr == ha) exp_pa = 1'b1;
      if (mq[k].live && hb != 0 && mq[k].addr == hb) exp_pb = 1'b1;
    end
    exp_ovf = m_ovf;
  endtask

  // advance the model by the rules of the arbiter, then step to posedge+1
  task automatic commit();
    logic m_req, bypass, killed;
    m_req  = m_valid && m_we && (m_waddr != 0);
    bypass = !core_we && (mq.size() == 0) && m_req;
    if (!core_we && mq.size() > 0) void'(mq.pop_front());
    if (core_we && core_waddr != 0)
      foreach (mq[k]) if (mq[k].addr == core_waddr) mq[k].live = 1'b0;
    killed = core_we && (core_waddr != 0) && (m_waddr == core_waddr);
    if (m_req && !bypass && !killed) begin
      if (mq.size() < D) mq.push_back('{live: 1'b1, addr: m_waddr, data: m_wdata});
      else m_ovf = 1'b1;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #1 rsn_i = 1'b0;
    core_we = 1'b1; core_waddr = 5'd4; core_wdata = 32'h77;
    m_valid = 1'b1; m_we = 1'b1; m_waddr = 5'd6; hz_a = 5'd6; hz_b = 5'd4;
    #2;
    checks++; if (rf_we_o !== 1'b0) begin errors++; $display("FAIL reset_we got=%b exp=0", rf_we_o); end
    checks++; if (m_issue_stall_o !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", m_issue_stall_o); end
    checks++; if ({hz_pending_a_o, hz_pending_b_o} !== 2'b00) begin errors++; $display("FAIL reset_pend got=%b%b exp=00", hz_pending_a_o, hz_pending_b_o); end
    checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", overflow_o); end
    @(posedge clk); @(negedge clk);
    rsn_i = 1'b1; core_we = 1'b0; m_valid = 1'b0; m_we = 1'b0; hz_a = '0; hz_b = '0;
    @(posedge clk); #1;
  endtask

  task automatic test_bypass();
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'h1234, 5'd5, 5'd0);
    checks++; if ({rf_we_o, rf_waddr_o, rf_wdata_o} !== {1'b1, 5'd5, 32'h1234}) begin
      errors++; $display("FAIL bypass got=%b/%0d/%h exp=1/5/1234", rf_we_o, rf_waddr_o, rf_wdata_o); end
    commit();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd0);
    checks++; if ({rf_we_o, m_issue_stall_o, hz_pending_a_o} !== 3'b000) begin
      errors++; $display("FAIL bypass_empty got we=%b stall=%b pend=%b exp=000", rf_we_o, m_issue_stall_o, hz_pending_a_o); end
    commit();
  endtask

  task automatic test_core_priority();
    drive(1'b1, 5'd3, 32'hA, 1'b1, 5'd7, 32'hB, 5'd7, 5'd0);
    checks++; if ({rf_we_o, rf_waddr_o, rf_wdata_o, hz_pending_a_o} !== {1'b1, 5'd3, 32'hA, 1'b0}) begin
      errors++; $display("FAIL prio_core got=%b/%0d/%h pend=%b exp=1/3/a pend=0", rf_we_o, rf_waddr_o, rf_wdata_o, hz_pending_a_o); end
    commit();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd7, 5'd0);
    checks++; if ({rf_we_o, rf_waddr_o, rf_wdata_o, hz_pending_a_o} !== {1'b1, 5'd7, 32'hB, 1'b1}) begin
      errors++; $display("FAIL prio_drain got=%b/%0d/%h pend=%b exp=1/7/b pend=1", rf_we_o, rf_waddr_o, rf_wdata_o, hz_pending_a_o); end
    commit();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd7, 5'd0);
    checks++; if ({rf_we_o, hz_pending_a_o} !== 2'b00) begin
      errors++; $display("FAIL prio_after got we=%b pend=%b exp=00", rf_we_o, hz_pending_a_o); end
    commit();
  endtask

  task automatic test_kill();
    drive(1'b1, 5'd1, 32'h11, 1'b1, 5'd9, 32'h99, 5'd0, 5'd0);
    commit();
    drive(1'b1, 5'd9, 32'h55, 1'b0, 5'd0, 32'h0, 5'd9, 5'd0);
    checks++; if ({rf_we_o, rf_waddr_o, rf_wdata_o, hz_pending_a_o} !== {1'b1, 5'd9, 32'h55, 1'b1}) begin
      errors++; $display("FAIL kill_core got=%b/%0d/%h pend=%b exp=1/9/55 pend=1", rf_we_o, rf_waddr_o, rf_wdata_o, hz_pending_a_o); end
    commit();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd9, 5'd0);
    checks++; if ({rf_we_o, hz_pending_a_o} !== 2'b00) begin
      errors++; $display("FAIL kill_pop got we=%b pend=%b exp=00", rf_we_o, hz_pending_a_o); end
    commit();
    // same-cycle M result to the core's destination is discarded
    drive(1'b1, 5'd12, 32'h1, 1'b1, 5'd12, 32'h2, 5'd0, 5'd12);
    checks++; if ({rf_we_o, rf_waddr_o, rf_wdata_o} !== {1'b1, 5'd12, 32'h1}) begin
      errors++; $display("FAIL kill_same got=%b/%0d/%h exp=1/12/1", rf_we_o, rf_waddr_o, rf_wdata_o); end
    commit();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd12);
    checks++; if ({rf_we_o, hz_pending_b_o} !== 2'b00) begin
      errors++; $display("FAIL kill_same_after got we=%b pend=%b exp=00", rf_we_o, hz_pending_b_o); end
    commit();
    // write to x0 is discarded
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h3, 5'd0, 5'd0);
    checks++; if (rf_we_o !== 1'b0) begin errors++; $display("FAIL x0_discard got we=%b exp=0", rf_we_o); end
    commit();
  endtask

  task automatic test_overflow();
    for (int i = 0; i < D + 2; i++) begin
      drive(1'b1, 5'd2, W'(i), 1'b1, R'(10 + i), W'(32'h100 + i), R'(10 + i), 5'd0);
      checks++; if (m_issue_stall_o !== exp_stall) begin
        errors++; $display("FAIL ovf_stall[%0d] got=%b exp=%b", i, m_issue_stall_o, exp_stall); end
      checks++; if (overflow_o !== exp_ovf) begin
        errors++; $display("FAIL ovf_flag[%0d] got=%b exp=%b", i, overflow_o, exp_ovf); end
      commit();
    end
    for (int i = 0; i < D + 2; i++) begin
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, R'(10 + i), 5'd0);
      checks++; if ({rf_we_o, rf_waddr_o, rf_wdata_o} !== {exp_we, exp_addr, exp_data}) begin
        errors++; $display("FAIL ovf_drain[%0d] got=%b/%0d/%h exp=%b/%0d/%h", i, rf_we_o, rf_waddr_o, rf_wdata_o, exp_we, exp_addr, exp_data); end
      checks++; if ({overflow_o, hz_pending_a_o} !== {1'b1, exp_pa}) begin
        errors++; $display("FAIL ovf_sticky[%0d] got=%b%b exp=1%b", i, overflow_o, hz_pending_a_o, exp_pa); end
      commit();
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 5'd1, 32'h0, 1'b1, R'(20 + i), W'(32'h200 + i), 5'd0, 5'd0);
      commit();
    end
    rsn_i = 1'b0;
    core_we = 1'b1; core_waddr = 5'd1; m_valid = 1'b1; m_we = 1'b1; m_waddr = 5'd25;
    hz_a = 5'd20; hz_b = 5'd23;
    #1;
    checks++; if ({rf_we_o, m_issue_stall_o, hz_pending_a_o, hz_pending_b_o, overflow_o} !== 5'b0) begin
      errors++; $display("FAIL rst_mid got we=%b stall=%b pend=%b%b ovf=%b exp=00000", rf_we_o, m_issue_stall_o, hz_pending_a_o, hz_pending_b_o, overflow_o); end
    mq.delete(); m_ovf = 1'b0;
    @(negedge clk);
    core_we = 1'b0; m_valid = 1'b0; m_we = 1'b0;
    rsn_i = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, R'(20 + i % 4), 5'd0);
      checks++; if ({rf_we_o, m_issue_stall_o, hz_pending_a_o} !== 3'b000) begin
        errors++; $display("FAIL rst_after[%0d] got we=%b stall=%b pend=%b exp=000", i, rf_we_o, m_issue_stall_o, hz_pending_a_o); end
      commit();
    end
  endtask

  // arrival order must equal write order across pointer wrap
  task automatic test_wrap();
    logic mv;
    logic [W-1:0] exp_w;
    for (int i = 0; i < 30; i++) begin
      mv = (i < 20) && ($urandom_range(0, 3) != 0) && (mq.size() < 6);
      if (mv) exp_q.push_back(32'h8000_0000 | W'(i));
      drive((i < 20) && (i % 2 == 0), 5'd1, W'(i), mv, R'(16 + i % 8),
            32'h8000_0000 | W'(i), 5'd0, 5'd0);
      if (rf_we_o && rf_wdata_o[31]) begin
        exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hx;
        checks++; if (rf_wdata_o !== exp_w) begin
          errors++; $display("FAIL wrap_order[%0d] got=%h exp=%h", i, rf_wdata_o, exp_w); end
      end
      checks++; if ({rf_we_o, rf_waddr_o, rf_wdata_o} !== {exp_we, exp_addr, exp_data}) begin
        errors++; $display("FAIL wrap_port[%0d] got=%b/%0d/%h exp=%b/%0d/%h", i, rf_we_o, rf_waddr_o, rf_wdata_o, exp_we, exp_addr, exp_data); end
      commit();
    end
    checks++; if (exp_q.size() != 0) begin
      errors++; $display("FAIL wrap_lost got=%0d pending exp=0", exp_q.size()); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 200; i++) begin
      drive(1'($urandom_range(0, 1)), R'($urandom_range(0, 7)), $urandom,
            1'($urandom_range(0, 1)), R'($urandom_range(0, 7)), $urandom,
            R'($urandom_range(0, 7)), R'($urandom_range(0, 7)));
      checks++; if (rf_we_o !== exp_we || (exp_we && {rf_waddr_o, rf_wdata_o} !== {exp_addr, exp_data})) begin
        errors++; $display("FAIL rnd_port[%0d] got=%b/%0d/%h exp=%b/%0d/%h", i, rf_we_o, rf_waddr_o, rf_wdata_o, exp_we, exp_addr, exp_data); end
      checks++; if ({m_issue_stall_o, hz_pending_a_o, hz_pending_b_o, overflow_o} !== {exp_stall, exp_pa, exp_pb, exp_ovf}) begin
        errors++; $display("FAIL rnd_status[%0d] got=%b%b%b%b exp=%b%b%b%b", i, m_issue_stall_o, hz_pending_a_o, hz_pending_b_o, overflow_o, exp_stall, exp_pa, exp_pb, exp_ovf); end
      commit();
    end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_core_priority();
    test_kill();
    test_overflow();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/m_ext_wb_arbiter.md
# m_ext_wb_arbiter

Writeback arbiter downstream of the M-extension pipeline's M5 stage. It shares the single register-file write port between the main pipeline writeback and M-extension results. The main pipeline always has priority. M results that lose arbitration wait in a small in-order buffer, which drives an issue stall toward decode and reports pending destinations for RAW hazard detection.

## Interface
Parameters:
- WORD_SIZE, 32, data width
- REG_SIZE, 5, register index width
- DEPTH, 8, buffer entries; must be ≥ 6, since 5 M-ops can be in flight

Ports:
- clk_i  in  1  clock
- rsn_i  in  1  reset; asynchronous, active-low
- core_we_i  in  1  main pipeline WB write enable
- core_waddr_i  in  REG_SIZE  main WB destination
- core_wdata_i  in  WORD_SIZE  main WB data
- m_valid_i  in  1  M5 valid
- m_we_i  in  1  M5 write enable
- m_waddr_i  in  REG_SIZE  M5 destination
- m_wdata_i  in  WORD_SIZE  M5 result
- rf_we_o  out  1  register-file write enable
- rf_waddr_o  out  REG_SIZE  register-file write address
- rf_wdata_o  out  WORD_SIZE  register-file write data
- m_issue_stall_o  out  1  decode must not issue a new M-op into M1
- hz_raddr_a_i, hz_raddr_b_i  in  REG_SIZE  hazard query addresses (rs1, rs2)
- hz_pending_a_o, hz_pending_b_o  out  1  the queried register has a live buffered write
- overflow_o  out  1  sticky error: an M result was lost

## Operation
- Incoming M request: m_valid_i & m_we_i & (m_waddr_i != 0). Writes to x0 are discarded.
- Buffer: circular FIFO of {live, waddr, wdata}, with head/tail pointers wrapping modulo DEPTH and a count of 0..DEPTH.
- Write-port selection each cycle, in priority order:
  - core_we_i=1: drive the core write.
  - Else, FIFO non-empty: pop the head; rf_we_o = head.live.
  - Else, incoming M request: bypass it directly to the port. It is not enqueued.
  - Else: rf_we_o = 0.
- Enqueue: an incoming M request is pushed at the tail whenever it is not bypassed. Push and pop in the same cycle are allowed; count is unchanged.
- Full, push requested, no pop: the result is dropped and overflow_o sets. overflow_o stays at 1 until reset.
- WAW kill: a core write with core_waddr_i != 0 clears live in every FIFO entry whose waddr matches. The same rule applies to a same-cycle incoming M request with a matching address, which is discarded and not enqueued.
  - Issue logic guarantees the core write is younger in every such case.
- Killed entries still occupy slots and still pop in order; their pop cycle produces rf_we_o = 0.
- m_issue_stall_o = (count ≥ DEPTH−5). This leaves room for the 5 M-ops that may already be in M1..M5.
- hz_pending_x_o = 1 iff hz_raddr_x_i != 0 and some occupied entry is live with a matching waddr. The in-flight stages M1–M5 are covered by the M pipeline's own destination outputs.
- Reset (rsn_i=0, async): count, head and tail go to 0; all live bits clear; overflow_o=0. While reset is held:
  - rf_we_o=0
  - m_issue_stall_o=0
  - hz_pending_*=0
  - Inputs are ignored.
- Reset asserted mid-operation discards all buffered results with no write.

## Timing
- All outputs are combinational from the current state and current inputs. There are no output registers.
- Core write: 0-cycle latency, written the same cycle.
- M result, bypassed: 0-cycle latency.
- M result, buffered: written in the first later cycle where core_we_i=0 and it is at the head. Minimum latency is 1 cycle.
- Buffer state (pointers, count, live bits, overflow) updates on the clk_i rising edge.
- Kills update live bits at the same edge as the causing core write.
- m_issue_stall_o reflects the registered count, so it changes one edge after a push or pop.
- Hazard outputs reflect the registered buffer only, so a pushed entry becomes visible the cycle after its push.

## Test plan
- M result x5=0x1234, core idle, FIFO empty → same cycle: rf_we_o=1, rf_waddr_o=5, rf_wdata_o=0x1234; count stays 0.
- Core write x3=0xA while M result x7=0xB → core written that cycle. Next cycle, core idle: x7=0xB written; hz_pending for x7 is 1 between the two cycles.
- M result x9 buffered, then core writes x9=0x55 while x9 is still buffered → entry killed; its pop cycle has rf_we_o=0; hz_pending for x9 drops to 0 after the kill edge.
- Core writes every cycle while M results arrive every cycle → count climbs; m_issue_stall_o=1 once count=3 (DEPTH=8). At DEPTH+1 results, overflow_o=1 and it stays 1.
- Wrap: 20 push/pop cycles with alternating core activity → write order exactly equals arrival order; pointers wrap with no loss.
- rsn_i pulsed low for half a cycle with 4 entries buffered → rf_we_o=0 immediately; count=0; no buffered writes appear after release.
